regfile_write_port: RTL and testbench

- Write-side companion of the 64-bit, 32-entry register file.
- Collects writeback traffic from two sources:
  - the in-order MEM/WB pipeline (ALU results and loads, with load extension);
  - a long-latency unit (divider/multiplier) result channel with valid/ready handshake.
- Merges them into the register file's single write port (RegWrite/RD/WriteData).
- Exposes a pending-write query so the hazard unit can stall reads of registers still queued.

---
 rtl/rv_pkg.sv | 18 +
 rtl/wb_result_queue.sv | 104 ++++++++++
 rtl/regfile_write_port.sv | 146 ++++++++++++++
 tb/tb_regfile_write_port.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the register-file write side: datapath width,
// register index width and the load funct3 encodings.
package rv_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_idx_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_result_queue.sv
// Small FIFO of long-latency results. Each entry carries a live bit so a
// younger pipeline write can cancel it in place (WAW) without reordering.
// Dead entries still occupy a slot and are popped normally.
module wb_result_queue
  import rv_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  reg_idx_t        push_rd,
  input  logic [XLEN-1:0] push_data,
  input  logic            push_live,
  input  logic            pop,
  input  logic            kill_en,
  input  reg_idx_t        kill_rd,
  input  reg_idx_t        q_rs1,
  input  reg_idx_t        q_rs2,
  output logic            q_hit1,
  output logic            q_hit2,
  output logic            head_live,
  output reg_idx_t        head_rd,
  output logic [XLEN-1:0] head_data,
  output logic            empty,
  output logic            full
);

  localparam int AW = $clog2(QDEPTH);

  logic [AW:0]     head_r;
  logic [AW:0]     tail_r;
  reg_idx_t        rd_r   [QDEPTH];
  logic [XLEN-1:0] data_r [QDEPTH];
  logic [QDEPTH-1:0] live_r;
  logic            hit1_s;
  logic            hit2_s;

  logic [AW-1:0] head_idx_s;
  logic [AW-1:0] tail_idx_s;

  assign head_idx_s = head_r[AW-1:0];
  assign tail_idx_s = tail_r[AW-1:0];

  // Extra pointer bit separates full (MSBs differ) from empty (all equal).
  assign empty = (head_r == tail_r);
  assign full  = (head_r[AW] != tail_r[AW]) && (head_idx_s == tail_idx_s);

  assign head_live = live_r[head_idx_s];
  assign head_rd   = rd_r[head_idx_s];
  assign head_data = data_r[head_idx_s];

  // Storage, pointers and live bits; kill first, then pop, then push.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_r <= '0;
      tail_r <= '0;
      live_r <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        rd_r[i]   <= '0;
        data_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (kill_en && live_r[i] && (rd_r[i] == kill_rd)) begin
          live_r[i] <= 1'b0;
        end
      end
      if (pop) begin
        // Freed slots are always dead so the hit scan needs no occupancy mask.
        live_r[head_idx_s] <= 1'b0;
        head_r <= head_r + {{AW{1'b0}}, 1'b1};
      end
      if (push) begin
        rd_r[tail_idx_s]   <= push_rd;
        data_r[tail_idx_s] <= push_data;
        live_r[tail_idx_s] <= push_live;
        tail_r <= tail_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Hazard query: any live entry targeting a nonzero query register.
  always_comb begin
    hit1_s = 1'b0;
    hit2_s = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (live_r[i] && (rd_r[i] == q_rs1) && (q_rs1 != 5'd0)) begin
        hit1_s = 1'b1;
      end else begin
        hit1_s = hit1_s;
      end
      if (live_r[i] && (rd_r[i] == q_rs2) && (q_rs2 != 5'd0)) begin
        hit2_s = 1'b1;
      end else begin
        hit2_s = hit2_s;
      end
    end
  end

  assign q_hit1 = hit1_s;
  assign q_hit2 = hit2_s;

endmodule

// File: rtl/regfile_write_port.sv
// Single write port of the register file. Pipeline writebacks (with load
// extension) always win; long-latency results wait in a small queue and
// drain in idle pipeline cycles.
module regfile_write_port
  import rv_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic            wb_regwrite,
  input  logic            wb_mem_to_reg,
  input  reg_idx_t        wb_rd,
  input  logic [XLEN-1:0] wb_alu_result,
  input  logic [XLEN-1:0] wb_mem_data,
  input  logic [2:0]      wb_funct3,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  reg_idx_t        lu_rd,
  input  logic [XLEN-1:0] lu_data,
  input  reg_idx_t        q_rs1,
  input  reg_idx_t        q_rs2,
  output logic            q_hit1,
  output logic            q_hit2,
  output logic            RegWrite,
  output reg_idx_t        RD,
  output logic [XLEN-1:0] WriteData
);

  // Select the addressed lane (offset aligned down to access size) and extend.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] dw,
                                                  input logic [2:0] addr,
                                                  input logic [2:0] f3);
    logic [5:0]      bitoff;
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    case (f3)
      F3_LB, F3_LBU: bitoff = {addr, 3'b000};
      F3_LH, F3_LHU: bitoff = {addr[2:1], 1'b0, 3'b000};
      F3_LW, F3_LWU: bitoff = {addr[2], 2'b00, 3'b000};
      default:       bitoff = 6'd0;
    endcase
    sh = dw >> bitoff;
    case (f3)
      F3_LB:   res = {{(XLEN-8){sh[7]}}, sh[7:0]};
      F3_LH:   res = {{(XLEN-16){sh[15]}}, sh[15:0]};
      F3_LW:   res = {{(XLEN-32){sh[31]}}, sh[31:0]};
      F3_LBU:  res = {{(XLEN-8){1'b0}}, sh[7:0]};
      F3_LHU:  res = {{(XLEN-16){1'b0}}, sh[15:0]};
      F3_LWU:  res = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: res = sh;  // LD and the unused 111 encoding
    endcase
    return res;
  endfunction

  logic            started_r;
  logic            regwrite_r;
  reg_idx_t        rd_r;
  logic [XLEN-1:0] wdata_r;

  logic            pipe_wr_s;
  logic [XLEN-1:0] wb_data_s;
  logic            pop_s;
  logic            push_s;
  logic            push_live_s;
  logic            lu_ready_s;
  logic            q_empty_s;
  logic            q_full_s;
  logic            head_live_s;
  reg_idx_t        head_rd_s;
  logic [XLEN-1:0] head_data_s;
  logic            regwrite_nxt_s;
  reg_idx_t        rd_nxt_s;
  logic [XLEN-1:0] wdata_nxt_s;

  assign pipe_wr_s   = wb_valid & wb_regwrite & (wb_rd != 5'd0);
  assign wb_data_s   = wb_mem_to_reg ? load_extend(wb_mem_data, wb_alu_result[2:0], wb_funct3)
                                     : wb_alu_result;
  assign lu_ready_s  = started_r & ~q_full_s;
  assign pop_s       = ~pipe_wr_s & ~q_empty_s;
  // rd=0 handshakes complete but leave nothing behind.
  assign push_s      = lu_valid & lu_ready_s & (lu_rd != 5'd0);
  // Same-cycle pipeline write to the same rd is younger: enqueue dead.
  assign push_live_s = ~(pipe_wr_s & (wb_rd == lu_rd));

  wb_result_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_rd   (lu_rd),
    .push_data (lu_data),
    .push_live (push_live_s),
    .pop       (pop_s),
    .kill_en   (pipe_wr_s),
    .kill_rd   (wb_rd),
    .q_rs1     (q_rs1),
    .q_rs2     (q_rs2),
    .q_hit1    (q_hit1),
    .q_hit2    (q_hit2),
    .head_live (head_live_s),
    .head_rd   (head_rd_s),
    .head_data (head_data_s),
    .empty     (q_empty_s),
    .full      (q_full_s)
  );

  // Arbitration: pipeline first, then queue head (dead head pops silently).
  always_comb begin
    regwrite_nxt_s = 1'b0;
    rd_nxt_s       = rd_r;
    wdata_nxt_s    = wdata_r;
    if (pipe_wr_s) begin
      regwrite_nxt_s = 1'b1;
      rd_nxt_s       = wb_rd;
      wdata_nxt_s    = wb_data_s;
    end else if (pop_s && head_live_s) begin
      regwrite_nxt_s = 1'b1;
      rd_nxt_s       = head_rd_s;
      wdata_nxt_s    = head_data_s;
    end else begin
      regwrite_nxt_s = 1'b0;
    end
  end

  // Registered write port plus the post-reset ready enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started_r  <= 1'b0;
      regwrite_r <= 1'b0;
      rd_r       <= '0;
      wdata_r    <= '0;
    end else begin
      started_r  <= 1'b1;
      regwrite_r <= regwrite_nxt_s;
      rd_r       <= rd_nxt_s;
      wdata_r    <= wdata_nxt_s;
    end
  end

  assign lu_ready  = lu_ready_s;
  assign RegWrite  = regwrite_r;
  assign RD        = rd_r;
  assign WriteData = wdata_r;

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed + random bench for regfile_write_port against a queue-based
// reference model of the write-port rules.
module tb_regfile_write_port;

  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0, wb_regwrite = 1'b0, wb_mem_to_reg = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [63:0] wb_alu_result = 64'd0, wb_mem_data = 64'd0;
  logic [2:0]  wb_funct3 = 3'd0;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_rd = 5'd0;
  logic [63:0] lu_data = 64'd0;
  logic [4:0]  q_rs1 = 5'd0, q_rs2 = 5'd0;
  logic        q_hit1, q_hit2;
  logic        RegWrite;
  logic [4:0]  RD;
  logic [63:0] WriteData;

  regfile_write_port #(.QDEPTH(QD)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_rd(wb_rd), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .wb_funct3(wb_funct3),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_hit1(q_hit1), .q_hit2(q_hit2),
    .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    bit          live;
  } ent_t;

  ent_t        mq[$];
  bit          m_started = 1'b0;
  logic        exp_rw = 1'b0;
  logic [4:0]  exp_rd = 5'd0;
  logic [63:0] exp_wd = 64'd0;
  bit          lu_blocked = 1'b0;
  int          compared = 0;
  int          mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load result built byte by byte from the memory doubleword.
  function automatic logic [63:0] load_ref(input logic [63:0] d, input logic [2:0] a,
                                           input logic [2:0] f3);
    int size;
    bit sgn;
    int off;
    logic [63:0] r;
    case (f3)
      3'd0: begin size = 1; sgn = 1'b1; end
      3'd1: begin size = 2; sgn = 1'b1; end
      3'd2: begin size = 4; sgn = 1'b1; end
      3'd4: begin size = 1; sgn = 1'b0; end
      3'd5: begin size = 2; sgn = 1'b0; end
      3'd6: begin size = 4; sgn = 1'b0; end
      default: begin size = 8; sgn = 1'b0; end
    endcase
    off = int'(a) - (int'(a) % size);
    r = 64'd0;
    for (int i = 0; i < size; i++) r[8*i +: 8] = d[8*(off+i) +: 8];
    if (sgn && r[8*size-1]) for (int i = size; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic bit m_ready();
    return m_started && (mq.size() < QD);
  endfunction

  function automatic bit m_hit(input logic [4:0] rs);
    if (rs == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].live && mq[i].rd == rs) return 1'b1;
    return 1'b0;
  endfunction

  // One clock edge of the reference model, using the inputs held at the edge.
  task automatic model_edge();
    bit   rdy;
    bit   pw;
    ent_t e;
    rdy = m_ready();
    pw  = wb_valid && wb_regwrite && (wb_rd != 5'd0);
    if (pw) begin
      exp_rw = 1'b1;
      exp_rd = wb_rd;
      exp_wd = wb_mem_to_reg ? load_ref(wb_mem_data, wb_alu_result[2:0], wb_funct3)
                             : wb_alu_result;
      foreach (mq[i]) if (mq[i].rd == wb_rd) mq[i].live = 1'b0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      exp_rw = e.live;
      if (e.live) begin
        exp_rd = e.rd;
        exp_wd = e.data;
      end
    end else begin
      exp_rw = 1'b0;
    end
    if (lu_valid && rdy && lu_rd != 5'd0) begin
      e.rd = lu_rd;
      e.data = lu_data;
      e.live = !(pw && wb_rd == lu_rd);
      mq.push_back(e);
    end
    lu_blocked = lu_valid && !rdy;
    m_started = 1'b1;
  endtask

  task automatic step(input string tag);
    #1;
    chk({tag, ":lu_ready"}, {63'd0, lu_ready}, {63'd0, m_ready()});
    chk({tag, ":q_hit1"}, {63'd0, q_hit1}, {63'd0, m_hit(q_rs1)});
    chk({tag, ":q_hit2"}, {63'd0, q_hit2}, {63'd0, m_hit(q_rs2)});
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ":RegWrite"}, {63'd0, RegWrite}, {63'd0, exp_rw});
    if (exp_rw) begin
      chk({tag, ":RD"}, {59'd0, RD}, {59'd0, exp_rd});
      chk({tag, ":WriteData"}, WriteData, exp_wd);
    end
  endtask

  task automatic set_wb(input logic v, input logic [4:0] rd, input logic [63:0] alu);
    wb_valid = v;
    wb_regwrite = v;
    wb_mem_to_reg = 1'b0;
    wb_rd = rd;
    wb_alu_result = alu;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] rd, input logic [63:0] d);
    lu_valid = v;
    lu_rd = rd;
    lu_data = d;
  endtask

  initial begin
    // Reset held low: everything zero.
    #2 reset = 1'b0;
    #1;
    chk("rst:RegWrite", {63'd0, RegWrite}, 64'd0);
    chk("rst:RD", {59'd0, RD}, 64'd0);
    chk("rst:WriteData", WriteData, 64'd0);
    chk("rst:lu_ready", {63'd0, lu_ready}, 64'd0);
    chk("rst:hits", {62'd0, q_hit1, q_hit2}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    step("rel");
    #1 chk("rel:lu_ready_after_edge", {63'd0, lu_ready}, 64'd1);

    // Pipeline ALU write and an x0 request.
    set_wb(1'b1, 5'd5, 64'h1234);
    step("alu5");
    chk("alu5:RD", {59'd0, RD}, 64'd5);
    chk("alu5:WriteData", WriteData, 64'h1234);
    set_wb(1'b1, 5'd0, 64'hDEAD);
    step("x0");
    chk("x0:RegWrite", {63'd0, RegWrite}, 64'd0);

    // Loads from a fixed doubleword.
    wb_mem_data = 64'h8877665544332211;
    set_wb(1'b1, 5'd3, 64'h1007); wb_mem_to_reg = 1'b1; wb_funct3 = 3'd0;
    step("lb7");
    chk("lb7:value", WriteData, 64'hFFFFFFFFFFFFFF88);
    set_wb(1'b1, 5'd3, 64'h1002); wb_mem_to_reg = 1'b1; wb_funct3 = 3'd5;
    step("lhu2");
    chk("lhu2:value", WriteData, 64'h4433);
    set_wb(1'b1, 5'd3, 64'h1004); wb_mem_to_reg = 1'b1; wb_funct3 = 3'd2;
    step("lw4");
    chk("lw4:value", WriteData, 64'hFFFFFFFF88776655);
    set_wb(1'b1, 5'd3, 64'h1000); wb_mem_to_reg = 1'b1; wb_funct3 = 3'd3;
    step("ld");
    chk("ld:value", WriteData, 64'h8877665544332211);

    // Fill the queue while the pipeline keeps the port busy.
    set_wb(1'b1, 5'd20, 64'h20); set_lu(1'b1, 5'd7, 64'hAA);
    step("fill7");
    set_wb(1'b1, 5'd21, 64'h21); set_lu(1'b1, 5'd8, 64'hBB);
    step("fill8");
    set_wb(1'b1, 5'd22, 64'h22); set_lu(1'b0, 5'd0, 64'd0); q_rs1 = 5'd8;
    #1;
    chk("full:lu_ready", {63'd0, lu_ready}, 64'd0);
    chk("full:q_hit1_8", {63'd0, q_hit1}, 64'd1);
    step("busy");
    set_wb(1'b0, 5'd0, 64'd0);
    step("drain7");
    chk("drain7:RD", {59'd0, RD}, 64'd7);
    chk("drain7:WriteData", WriteData, 64'hAA);
    step("drain8");
    chk("drain8:RD", {59'd0, RD}, 64'd8);
    chk("drain8:WriteData", WriteData, 64'hBB);
    step("drained");
    chk("drained:RegWrite", {63'd0, RegWrite}, 64'd0);
    #1 chk("drained:lu_ready", {63'd0, lu_ready}, 64'd1);

    // WAW kill.
    set_wb(1'b1, 5'd22, 64'h22); set_lu(1'b1, 5'd9, 64'h99);
    step("push9");
    set_wb(1'b1, 5'd9, 64'h55); set_lu(1'b0, 5'd0, 64'd0); q_rs1 = 5'd9;
    #1 chk("waw:hit9_before", {63'd0, q_hit1}, 64'd1);
    step("waw");
    chk("waw:WriteData", WriteData, 64'h55);
    #1 chk("waw:hit9_after", {63'd0, q_hit1}, 64'd0);
    set_wb(1'b0, 5'd0, 64'd0);
    step("deadpop");
    chk("deadpop:RegWrite", {63'd0, RegWrite}, 64'd0);

    // Reset with two entries queued and a write in flight.
    set_wb(1'b1, 5'd23, 64'h23); set_lu(1'b1, 5'd10, 64'h1010);
    step("pre_rst_a");
    set_wb(1'b1, 5'd24, 64'h24); set_lu(1'b1, 5'd11, 64'h1111); q_rs1 = 5'd10;
    step("pre_rst_b");
    set_wb(1'b0, 5'd0, 64'd0); set_lu(1'b0, 5'd0, 64'd0);
    #2 reset = 1'b0;
    #1;
    chk("midrst:RegWrite", {63'd0, RegWrite}, 64'd0);
    chk("midrst:lu_ready", {63'd0, lu_ready}, 64'd0);
    chk("midrst:q_hit1", {63'd0, q_hit1}, 64'd0);
    mq.delete();
    m_started = 1'b0;
    exp_rw = 1'b0;
    lu_blocked = 1'b0;
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("postrst");
      chk("postrst:RegWrite", {63'd0, RegWrite}, 64'd0);
    end

    // Random traffic with small rd range to provoke collisions.
    for (int n = 0; n < 500; n++) begin
      wb_valid      = ($urandom_range(0, 3) != 0);
      wb_regwrite   = ($urandom_range(0, 4) != 0);
      wb_mem_to_reg = $urandom_range(0, 1);
      wb_rd         = 5'($urandom_range(0, 7));
      wb_alu_result = {$urandom, $urandom};
      wb_mem_data   = {$urandom, $urandom};
      wb_funct3     = 3'($urandom_range(0, 7));
      if (!lu_blocked) begin
        lu_valid = ($urandom_range(0, 1) != 0);
        lu_rd    = 5'($urandom_range(0, 7));
        lu_data  = {$urandom, $urandom};
      end
      q_rs1 = 5'($urandom_range(0, 7));
      q_rs2 = 5'($urandom_range(0, 7));
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
